// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, 16x oversampled, with a hold-until-read byte register.
// Optional even-parity frame (9 bits) when UART_RX_PARITY_EN is defined.
module uart_rx #(
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_rate,
  input  logic       RX_receive,
  input  logic       rd_en,
  output logic       e_baudrate,
  output logic       busy,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error,
`ifdef UART_RX_PARITY_EN
  output logic       parity_error,
`endif
  output logic       overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;
  logic [TW-1:0]          tick_q, tick_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_d;
  logic                   valid_d, ovr_d, fe_d;
  logic                   complete;
`ifdef UART_RX_PARITY_EN
  logic                   pbad_q, pbad_d, perr_d;
`endif

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    data_d     = data;
    valid_d    = data_valid;
    ovr_d      = overrun;
    fe_d       = 1'b0;
    e_baudrate = 1'b0;
    busy       = 1'b1;
    complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_d     = pbad_q;
    perr_d     = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (!rxs) begin
          state_d = S_START;
          tick_d  = '0;
`ifdef UART_RX_PARITY_EN
          pbad_d  = 1'b0;
`endif
        end
      end

      S_START: begin
        e_baudrate = 1'b1;
        if (baud_rate) begin
          if (tick_q == TICK_MID) begin
            tick_d = '0;
            if (rxs) begin
              state_d = S_IDLE;
            end else begin
              bit_d   = '0;
              state_d = S_DATA;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        e_baudrate = 1'b1;
        if (baud_rate) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rxs, shift_q[7:1]};
            bit_d   = bit_q + 1'b1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        e_baudrate = 1'b1;
        if (baud_rate) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            state_d = S_STOP;
            if (^{shift_q, rxs}) begin
              perr_d = 1'b1;
              pbad_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        e_baudrate = 1'b1;
        if (baud_rate) begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (rxs) begin
              state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
              complete = !pbad_q;
`else
              complete = 1'b1;
`endif
            end else begin
              fe_d    = 1'b1;
              state_d = S_WAIT_HIGH;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      S_WAIT_HIGH: begin
        if (rxs) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // A read in the completion cycle frees the register for the new byte.
    if (complete) begin
      if (!data_valid || rd_en) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rd_en && data_valid) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      sync_q       <= '1;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      data         <= '0;
      data_valid   <= 1'b0;
      frame_error  <= 1'b0;
      overrun      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      pbad_q       <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[SYNC_STAGES-2:0], RX_receive};
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      data         <= data_d;
      data_valid   <= valid_d;
      frame_error  <= fe_d;
      overrun      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      pbad_q       <= pbad_d;
      parity_error <= perr_d;
`endif
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the existing UART transmitter on the same serial link.
- Samples the asynchronous serial line using a 16x oversampling tick from the shared baud generator. It enables that generator only while a frame is in progress.
- Assembles LSB-first bytes and presents each one through a hold-until-acknowledged register to the bus-side peripheral logic, with frame-error and overrun status.

Parameters:
- OVERSAMPLE, 16, ticks per bit period; must be even and at least 4.
- SYNC_STAGES, 2, number of flip-flop stages synchronising RX_receive into clk; at least 2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- baud_rate  input  1  one-clk-wide oversample tick. The generator holds its phase at 0 while e_baudrate is low.
- RX_receive  input  1  asynchronous serial line; idle level is high
- rd_en  input  1  bus-side acknowledge; consumes the held byte
- e_baudrate  output  1  enables the baud tick generator
- busy  output  1  a frame is in progress (state is not idle)
- data  output  8 (uint8)  last received byte
- data_valid  output  1  data holds an unread byte
- frame_error  output  1  one-clk pulse when a bad stop bit is sampled
- overrun  output  1  sticky; a byte was lost because the previous one was unread

Behaviour:
- Reset values:
  - All outputs are 0.
  - Synchroniser stages are 1.
  - State is idle; tick, bit and shift counters are 0.
- Input path: RX_receive passes through SYNC_STAGES flip-flops. Only the synchronised signal rxs is used anywhere.
- FSM states: idle, start, data_bits, stop, wait_high.
- idle:
  - e_baudrate=0, busy=0.
  - When rxs==0, go to start and clear the tick counter.
- start:
  - e_baudrate=1, busy=1.
  - Count baud_rate ticks. At tick OVERSAMPLE/2 (mid start bit), sample rxs.
  - If rxs==1, the low was a glitch: go to idle with no outputs affected.
  - If rxs==0, clear the tick and bit counters and go to data_bits.
- data_bits:
  - Every OVERSAMPLE ticks, sample rxs into shift[7] while shifting right. Bits arrive LSB first.
  - After the 8th sample, go to stop.
- stop:
  - At OVERSAMPLE ticks, sample rxs.
  - If rxs==1: the frame is good; go to idle.
  - If rxs==0: assert frame_error for exactly one clk, discard the byte, and go to wait_high.
- wait_high:
  - e_baudrate=0, busy=1.
  - Stay until rxs==1, then go to idle. A break condition therefore produces only one frame_error.
- Good-frame completion cycle C:
  - If data_valid==0, or rd_en==1 in cycle C: data<=shift and data_valid<=1, both visible at C+1. overrun is unchanged.
  - If data_valid==1 and rd_en==0: the new byte is dropped, data keeps the old byte, and overrun<=1.
- rd_en with data_valid==1 and no completion in the same cycle: data_valid<=0 and overrun<=0 next cycle. data retains its value.
- rd_en with data_valid==0 has no effect.
- Latency: data_valid rises 1 clk after the stop-bit sample tick.
- Ticks are counted only in cycles where baud_rate==1. Counters wrap to 0 at each sample point.
- rst asserted mid-frame: returns to idle next cycle with all reset values, dropping the partial byte.
- Holding rxs low forever gives exactly one frame_error, then the block stays in wait_high with no data_valid.

Optional Feature:
- UART_RX_PARITY_EN
- Defined:
  - A state parity sits between data_bits and stop. It samples one extra bit at OVERSAMPLE ticks.
  - A frame is good only if the 8 data bits plus the parity bit have even parity.
  - An extra output parity_error (1 bit, reset 0) pulses for one clk on mismatch. The byte is discarded with no data_valid, and the FSM continues to stop normally.
- Undefined: frame is 8N1, and neither the parity state nor the parity_error port exists.

Test Plan:
- Byte 0xA5 sent 8N1 at 16 ticks/bit, tick every 4 clk -> data_valid=1 with data=0xA5. frame_error=0, overrun=0, busy=0 afterwards.
- Low glitch of 5 ticks on idle line -> back to idle after the mid-start sample. data_valid and frame_error stay 0; e_baudrate drops.
- 0x3C sent with stop bit 0, then line held low for 40 bit times -> exactly one frame_error pulse and no data_valid. Returns to idle once line goes high; a following 0x81 is received correctly.
- 0x11 then 0x22 sent with no rd_en -> data=0x11, data_valid=1, overrun=1. rd_en then clears both flags.
- 0x55 received with rd_en asserted in the completion cycle of the next byte 0x66 -> data=0x66, data_valid=1, overrun=0.
- rst pulsed in the middle of bit 4 of 0xFF -> all outputs 0 next cycle. The next full frame 0x0F is received correctly.
